// File: rtl/mem_arbiter_if.sv
// Bus interface for mem_arbiter: both requester ports, the burst lock, the
// read-data return path, the core stall indication and the shared ram port.
// The slave modport is the arbiter's view; master is the environment's view
// (requesters plus the ram).
interface mem_arbiter_if #(
  parameter int DW = 32
);
  // Port 0: CPU load/store path
  logic          req0;
  logic          we0;
  logic [DW-1:0] addr0;
  logic [DW-1:0] wd0;
  logic          sel0;
  logic          gnt0;
  logic [DW-1:0] rdata0;
  logic          rvalid0;
  logic          stall0;

  // Port 1: program/debug loader
  logic          req1;
  logic          we1;
  logic [DW-1:0] addr1;
  logic [DW-1:0] wd1;
  logic          sel1;
  logic          lock1;
  logic          gnt1;
  logic [DW-1:0] rdata1;
  logic          rvalid1;

  // Shared ram port
  logic          ram_we;
  logic [DW-1:0] ram_a;
  logic [DW-1:0] ram_wd;
  logic          ram_sel;
  logic [DW-1:0] ram_rd;

  // Port-0 stall statistics
  logic [15:0]   stall_cnt;

  modport slave (
    input  req0, we0, addr0, wd0, sel0,
    input  req1, we1, addr1, wd1, sel1, lock1,
    input  ram_rd,
    output gnt0, rdata0, rvalid0, stall0,
    output gnt1, rdata1, rvalid1,
    output ram_we, ram_a, ram_wd, ram_sel,
    output stall_cnt
  );

  modport master (
    output req0, we0, addr0, wd0, sel0,
    output req1, we1, addr1, wd1, sel1, lock1,
    output ram_rd,
    input  gnt0, rdata0, rvalid0, stall0,
    input  gnt1, rdata1, rvalid1,
    input  ram_we, ram_a, ram_wd, ram_sel,
    input  stall_cnt
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single data ram between the CPU load/store path
// (port 0) and the program/debug loader (port 1). A three-state grant FSM
// (IDLE/G0/G1) gives one access per cycle with round-robin fairness; port 1
// may hold the ram for a bounded burst while asserting lock1. Read data is
// registered back to the winning port with a one-cycle rvalid pulse.
// Optional feature: define MEM_ARB_STALL_CNT_EN to build a saturating
// counter of port-0 stall cycles on stall_cnt; otherwise stall_cnt is 0.
// Reset (rst) is synchronous and active-low.
module mem_arbiter #(
  parameter int DW        = 32,
  parameter int MAX_BURST = 8
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  localparam int             BW          = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0]  BURST_LIMIT = BW'(MAX_BURST - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G1   = 2'd2
  } state_t;

  state_t        state;
  state_t        next_state;
  logic          last;       // last granted port: 0 or 1
  logic          last_eff;   // last granted port including the current grant
  logic [BW-1:0] burst_cnt;

  logic          gnt0_q;
  logic          gnt1_q;
  logic          rvalid0_q;
  logic          rvalid1_q;
  logic [DW-1:0] rdata0_q;
  logic [DW-1:0] rdata1_q;

  // Next-grant decision from the requests presented at this edge.
  // NOTE: every always_comb output gets a default first so no path can leave it
  // unassigned and infer a latch.
  always_comb begin
    next_state = IDLE;
    // While a grant is in progress, that grant is the most recent one even
    // though `last` is only written on the edge leaving it.
    last_eff = last;
    if (state == G0) last_eff = 1'b0;
    if (state == G1) last_eff = 1'b1;

    if (bus.req0 && bus.req1) begin
      if (state == G1) begin
        next_state = (bus.lock1 && (burst_cnt < BURST_LIMIT)) ? G1 : G0;
      end else begin
        next_state = last_eff ? G0 : G1;
      end
    end else if (bus.req0) begin
      next_state = G0;
    end else if (bus.req1) begin
      next_state = G1;
    end
  end

  // Grant FSM with registered grant, read-data and rvalid outputs.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      last      <= 1'b1;
      burst_cnt <= '0;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      state  <= next_state;
      gnt0_q <= (next_state == G0);
      gnt1_q <= (next_state == G1);

      if (state == G0) last <= 1'b0;
      if (state == G1) last <= 1'b1;

      // Burst length counts retained port-1 grants while port 0 is waiting.
      if (next_state != G1) begin
        burst_cnt <= '0;
      end else if (state == G1 && bus.req0) begin
        burst_cnt <= burst_cnt + BW'(1);
      end

      // Read completion: capture the ram at the end of the grant cycle.
      rvalid0_q <= (state == G0) && !bus.we0;
      rvalid1_q <= (state == G1) && !bus.we1;
      if (state == G0 && !bus.we0) rdata0_q <= bus.ram_rd;
      if (state == G1 && !bus.we1) rdata1_q <= bus.ram_rd;
    end
  end

  // Ram port mux: the granted port drives the ram; writes are blocked in reset.
  always_comb begin
    bus.ram_we  = 1'b0;
    bus.ram_a   = '0;
    bus.ram_wd  = '0;
    bus.ram_sel = 1'b0;
    case (state)
      G0: begin
        bus.ram_we  = bus.we0 & rst;
        bus.ram_a   = bus.addr0;
        bus.ram_wd  = bus.wd0;
        bus.ram_sel = bus.sel0;
      end
      G1: begin
        bus.ram_we  = bus.we1 & rst;
        bus.ram_a   = bus.addr1;
        bus.ram_wd  = bus.wd1;
        bus.ram_sel = bus.sel1;
      end
      default: ;
    endcase
  end

  assign bus.gnt0    = gnt0_q;
  assign bus.gnt1    = gnt1_q;
  assign bus.rvalid0 = rvalid0_q;
  assign bus.rvalid1 = rvalid1_q;
  assign bus.rdata0  = rdata0_q;
  assign bus.rdata1  = rdata1_q;
  assign bus.stall0  = bus.req0 & ~gnt0_q;

`ifdef MEM_ARB_STALL_CNT_EN
  logic [15:0] stall_cnt_q;

  // Saturating count of cycles in which port 0 waits for the ram.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt_q <= '0;
    end else if (bus.stall0 && stall_cnt_q != 16'hFFFF) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
`else
  assign bus.stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter. A behavioural model tracks which port
// owns the ram each cycle (round-robin, bounded lock bursts), the expected
// read data from its own copy of the ram contents, and the stall count.
// Directed scenarios cover reset, single read latency, tie alternation, a
// locked burst and reset during a write; a randomized phase follows.
module tb_mem_arbiter;
  localparam int DW        = 32;
  localparam int MAX_BURST = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if #(.DW(DW)) bus ();

  mem_arbiter #(.DW(DW), .MAX_BURST(MAX_BURST)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Environment ram (combinational read) and the model's private copy.
  logic [31:0] bram [16];
  logic [31:0] mmem [16];
  assign bus.ram_rd = bram[bus.ram_a[5:2]];

  int checks   = 0;
  int failures = 0;

  // Model state
  int          m_port;   // port owning the ram this cycle, -1 = none
  bit          m_last;   // most recently granted port
  int          m_run;    // retained port-1 grants while port 0 waits
  bit          m_rv0, m_rv1;
  logic [31:0] m_rd0, m_rd1;
  int          m_cnt;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_port = -1; m_last = 1'b1; m_run = 0;
    m_rv0 = 1'b0; m_rv1 = 1'b0; m_rd0 = '0; m_rd1 = '0; m_cnt = 0;
  endtask

  // Advance the model across the coming edge using the inputs now presented.
  task automatic model_step();
    bit r0, r1;
    int nxt;
    if (!rst) begin
      model_reset();
      return;
    end
    r0 = bus.req0;
    r1 = bus.req1;
    m_rv0 = 1'b0;
    m_rv1 = 1'b0;
    if (m_port == 0) begin
      if (bus.we0) mmem[bus.addr0[5:2]] = bus.wd0;
      else begin m_rv0 = 1'b1; m_rd0 = mmem[bus.addr0[5:2]]; end
    end else if (m_port == 1) begin
      if (bus.we1) mmem[bus.addr1[5:2]] = bus.wd1;
      else begin m_rv1 = 1'b1; m_rd1 = mmem[bus.addr1[5:2]]; end
    end
`ifdef MEM_ARB_STALL_CNT_EN
    if (r0 && m_port != 0 && m_cnt < 65535) m_cnt++;
`endif
    if (!r0 && !r1) nxt = -1;
    else if (r0 && !r1) nxt = 0;
    else if (!r0 && r1) nxt = 1;
    else if (m_port == 1) nxt = (bus.lock1 && (m_run + 1 < MAX_BURST)) ? 1 : 0;
    else if (m_port == 0) nxt = 1;
    else nxt = m_last ? 0 : 1;
    if (nxt == 1 && m_port == 1 && r0) m_run++;
    if (nxt != 1) m_run = 0;
    if (m_port >= 0) m_last = (m_port == 1);
    m_port = nxt;
  endtask

  // One clock: compare every output mid-cycle, step the model, apply ram write.
  task automatic cycle();
    logic        e_we, e_sel, w_we;
    logic [31:0] e_a, e_wd, w_a, w_wd;
    @(negedge clk);
    e_we = 1'b0; e_sel = 1'b0; e_a = '0; e_wd = '0;
    if (m_port == 0) begin
      e_we = bus.we0 & rst; e_a = bus.addr0; e_wd = bus.wd0; e_sel = bus.sel0;
    end else if (m_port == 1) begin
      e_we = bus.we1 & rst; e_a = bus.addr1; e_wd = bus.wd1; e_sel = bus.sel1;
    end
    check("gnt0",    bus.gnt0,    m_port == 0);
    check("gnt1",    bus.gnt1,    m_port == 1);
    check("stall0",  bus.stall0,  bus.req0 && m_port != 0);
    check("ram_we",  bus.ram_we,  e_we);
    check("ram_a",   bus.ram_a,   e_a);
    check("ram_wd",  bus.ram_wd,  e_wd);
    check("ram_sel", bus.ram_sel, e_sel);
    check("rvalid0", bus.rvalid0, m_rv0);
    check("rvalid1", bus.rvalid1, m_rv1);
    check("rdata0",  bus.rdata0,  m_rd0);
    check("rdata1",  bus.rdata1,  m_rd1);
    check("stall_cnt", bus.stall_cnt, m_cnt);
    w_we = bus.ram_we; w_a = bus.ram_a; w_wd = bus.ram_wd;
    model_step();
    @(posedge clk);
    #1;
    if (w_we) bram[w_a[5:2]] = w_wd;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    cycle();
    rst = 1'b1;
  endtask

  initial begin
    bit found;
    bus.req0 = 0; bus.we0 = 0; bus.addr0 = '0; bus.wd0 = '0; bus.sel0 = 0;
    bus.req1 = 0; bus.we1 = 0; bus.addr1 = '0; bus.wd1 = '0; bus.sel1 = 0;
    bus.lock1 = 0;
    for (int i = 0; i < 16; i++) begin
      bram[i] = 32'h1000_0000 + i;
      mmem[i] = 32'h1000_0000 + i;
    end
    bram[4] = 32'hDEAD_BEEF;
    mmem[4] = 32'hDEAD_BEEF;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check("rst_gnt0",      bus.gnt0,      1'b0);
    check("rst_gnt1",      bus.gnt1,      1'b0);
    check("rst_rvalid0",   bus.rvalid0,   1'b0);
    check("rst_rdata0",    bus.rdata0,    32'h0);
    check("rst_stall_cnt", bus.stall_cnt, 16'h0);
    rst = 1'b1;

    // Single read at 0x10: grant next cycle, data one cycle later; the
    // requester drops req in its grant cycle and the access still completes.
    bus.req0 = 1; bus.we0 = 0; bus.addr0 = 32'h10;
    cycle();
    check("rd_gnt0", bus.gnt0, 1'b1);
    bus.req0 = 0;
    cycle();
    check("rd_rvalid0", bus.rvalid0, 1'b1);
    check("rd_rdata0",  bus.rdata0,  32'hDEAD_BEEF);
    cycle();
    check("rd_rvalid0_pulse", bus.rvalid0, 1'b0);

    // Tie from IDLE after reset: G0,G1,G0,G1
    do_reset();
    bus.req0 = 1; bus.req1 = 1; bus.we1 = 0; bus.addr1 = 32'h24;
    cycle();
    for (int k = 0; k < 4; k++) begin
      check("tie_gnt0",   bus.gnt0,   (k % 2) == 0);
      check("tie_gnt1",   bus.gnt1,   (k % 2) == 1);
      check("tie_stall0", bus.stall0, (k % 2) == 1);
      cycle();
    end

    // Locked burst: MAX_BURST consecutive G1 grants then G0, twice over
    bus.lock1 = 1;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (bus.gnt0) found = 1;
      else cycle();
    end
    check("burst_sync", found, 1'b1);
    for (int r = 0; r < 2; r++) begin
      cycle();
      for (int i = 0; i < MAX_BURST; i++) begin
        check("burst_gnt1", bus.gnt1, 1'b1);
        cycle();
      end
      check("burst_end_gnt0", bus.gnt0, 1'b1);
    end
    bus.lock1 = 0; bus.req0 = 0; bus.req1 = 0;
    cycle();

    // Reset in port 1's write grant cycle aborts the write
    do_reset();
    bus.req1 = 1; bus.we1 = 1; bus.addr1 = 32'h20; bus.wd1 = 32'h55;
    cycle();
    check("abort_gnt1", bus.gnt1, 1'b1);
    rst = 1'b0;
    #1;
    check("abort_ram_we", bus.ram_we, 1'b0);
    cycle();
    check("abort_idle_gnt1", bus.gnt1, 1'b0);
    check("abort_rvalid1",   bus.rvalid1, 1'b0);
    check("abort_mem",       bram[8], 32'h1000_0008);
    bus.req1 = 0; bus.we1 = 0;
    rst = 1'b1;
    cycle();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        bus.req0 = $urandom_range(0, 1); bus.we0 = $urandom_range(0, 1);
        bus.addr0 = $urandom; bus.wd0 = $urandom; bus.sel0 = $urandom_range(0, 1);
      end
      if ($urandom_range(0, 2) == 0) begin
        bus.req1 = $urandom_range(0, 1); bus.we1 = $urandom_range(0, 1);
        bus.addr1 = $urandom; bus.wd1 = $urandom; bus.sel1 = $urandom_range(0, 1);
      end
      if ($urandom_range(0, 7) == 0) bus.lock1 = $urandom_range(0, 1);
      rst = ($urandom_range(0, 199) != 0);
      cycle();
    end
    rst = 1'b1;

`ifdef MEM_ARB_STALL_CNT_EN
    // Hold port 0 mostly blocked by a locked port 1 until the counter saturates
    do_reset();
    bus.req0 = 1; bus.we0 = 0; bus.req1 = 1; bus.we1 = 0; bus.lock1 = 1;
    for (int n = 0; n < 74000; n++) cycle();
    check("stall_cnt_sat", bus.stall_cnt, 16'hFFFF);
`else
    bus.req0 = 1; bus.req1 = 1; bus.lock1 = 1;
    for (int n = 0; n < 40; n++) cycle();
    check("stall_cnt_off", bus.stall_cnt, 16'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
